sprite_palette_bank: RTL and testbench
======================================

# sprite_palette_bank

Runtime-loadable, multi-bank colour palette for the sprite pipeline. Converts a per-pixel colour index from sprite ROM into 12-bit RGB through a registered two-stage lookup, replacing fixed per-sprite palette constants. Bank switches (player-2 colours, alternate costumes) are deferred to frame boundaries to prevent tearing. Sits between the sprite ROM address/fetch stage and the VGA colour mux.

## Interface

- `INDEX_W`, default 4: colour index width; entries per bank = 2^INDEX_W.
- `BANKS`, default 4: number of palette banks (power of two, ≥2).
- `COLOR_W`, default 4: bits per colour channel.
- `FLASH_FRAMES`, default 8: hit-flash duration in frames (used only with `PALETTE_FLASH_EN`).

Ports:

- `Clk` in 1: single clock.
- `Reset` in 1: synchronous, active-high reset.
- `wr_en` in 1: palette write strobe; honoured only when `wr_ready`=1.
- `wr_bank` in log2(BANKS): bank to write.
- `wr_index` in INDEX_W: entry to write.
- `wr_rgb` in 3·COLOR_W: {red, green, blue} to store.
- `wr_ready` out 1: 0 during post-reset clear, else 1.
- `bank_req_valid` in 1: request a new active bank.
- `bank_req` in log2(BANKS): requested bank.
- `frame_start` in 1: one-cycle pulse at start of vertical blank.
- `active_bank` out log2(BANKS): bank currently used for lookups.
- `pix_valid` in 1: `index` is valid this cycle.
- `index` in INDEX_W: pixel colour index.
- `flash_trig` in 1: start hit flash.
- `pix_valid_out` out 1: `pix_valid` delayed 2 cycles.
- `transparent` out 1: delayed (index == 0); aligned with `pix_valid_out`.
- `red`, `green`, `blue` out COLOR_W each: looked-up colour.

## Operation

FSM states: `CLEAR` and `RUN`.

- **Reset:**
  - FSM enters `CLEAR` and clears the address counter.
  - Outputs reset to: `wr_ready`=0, `active_bank`=0, `pix_valid_out`=0, `transparent`=0, `red`/`green`/`blue`=0.
  - Pending bank request cleared; flash counter = 0.
- **CLEAR:**
  - Writes 0 to one entry per cycle, address = {bank, index}, walking 0 … BANKS·2^INDEX_W − 1.
  - On the last address, moves to `RUN` next cycle; `wr_ready`=1 from that cycle.
  - `wr_en` is ignored during `CLEAR`.
  - Lookups still run; they read 0.
- **RUN writes:**
  - Take effect at the clock edge.
  - A read of the same entry in the same cycle returns the old data (read-first).
- **Bank select:**
  - `bank_req_valid` latches `bank_req` into a pending register; a later request overwrites an earlier one.
  - On `frame_start`, if a request is pending, `active_bank` ← pending and pending is cleared.
  - If `bank_req_valid` and `frame_start` coincide, the new request applies at that same `frame_start`.
- **Lookup pipeline:**
  - Stage 1 registers {`active_bank`, `index`}, `pix_valid`, and (index==0).
  - Stage 2 registers the storage read into RGB.
  - The bank is sampled at stage 1, so a pixel in flight during a switch uses its stage-1 bank.
  - When `pix_valid`=0, RGB outputs still update; consumers must qualify with `pix_valid_out`.
- **Reset mid-operation:** restarts `CLEAR` and flushes the pipeline; all palette contents are lost.

## Timing

- Lookup latency is 2 cycles, fully pipelined, one pixel per cycle.
- Clear takes BANKS·2^INDEX_W cycles: 64 with defaults.
- Bank switch is visible on `active_bank` the cycle after the `frame_start` edge.
- Write-to-read latency is 1 cycle: a lookup issued the cycle after the write sees the new data.

## Configuration

`PALETTE_FLASH_EN` controls the hit-flash effect.

- **Defined:**
  - `flash_trig` loads a frame counter with `FLASH_FRAMES`; it retriggers (reloads) if already nonzero.
  - The counter decrements on each `frame_start` while nonzero.
  - While the counter is nonzero and bit 0 is 1, stage 2 outputs all channels = 2^COLOR_W − 1 for non-transparent pixels.
  - Transparent pixels are unchanged.
  - `flash_trig` coinciding with `frame_start` results in a reload with no decrement.
- **Undefined:** `flash_trig` is ignored, there is no counter logic, and output is the pure lookup.

## Test plan

1. **Reset and clear:** Assert `Reset` 1 cycle.
   - Expect `wr_ready`=0 for 64 cycles, then 1.
   - Looking up bank 0 index 5 during and after the clear returns RGB 000.
2. **Write and read back:** Write bank 0 index 1 = 0x320 and bank 0 index 0 = 0xF0F.
   - `index`=1 gives RGB 3,2,0 two cycles later with `transparent`=0.
   - `index`=0 gives 0xF0F with `transparent`=1.
3. **Read-first:** Write bank 0 index 2 = 0xCCA and look up index 2 in the same cycle.
   - That lookup returns the old value 000.
   - A lookup the next cycle returns 0xCCA.
4. **Deferred bank switch:** Bank 1 index 3 = 0x952 and bank 0 index 3 = 0x100; `bank_req`=1 mid-frame with a continuous index-3 stream.
   - Output stays 0x100 until the `frame_start` cycle + 1.
   - Output then becomes 0x952 and `active_bank`=1.
   - `bank_req_valid` coincident with `frame_start` also switches.
5. **Flash (`PALETTE_FLASH_EN`):** `flash_trig`, then 8 `frame_start` pulses.
   - Non-transparent output is 0xFFF on frames where the count is odd: 7, 5, 3, 1.
   - Output returns to the palette colour after count 0.
   - Index-0 pixels remain unchanged throughout.
6. **Reset mid-stream:** Assert `Reset` with `pix_valid`=1.
   - `pix_valid_out`=0 the next cycle.
   - The previously written entry reads 000 after the clear.

Source files
------------

// File: rtl/sprite_palette_bank.sv
// sprite_palette_bank: runtime-loadable multi-bank colour palette.
// Converts a per-pixel colour index into {red, green, blue} through a
// registered two-stage lookup. After reset the whole palette is cleared one
// entry per cycle before writes are accepted. Bank switches requested at any
// time are deferred to the next frame_start pulse to avoid tearing.
// Optional feature: define PALETTE_FLASH_EN to enable the hit-flash effect
// (non-transparent pixels forced to full white on odd flash-frame counts).
module sprite_palette_bank #(
    parameter int INDEX_W      = 4,
    parameter int BANKS        = 4,
    parameter int COLOR_W      = 4,
    parameter int FLASH_FRAMES = 8
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       wr_en,
    input  logic [$clog2(BANKS)-1:0]   wr_bank,
    input  logic [INDEX_W-1:0]         wr_index,
    input  logic [3*COLOR_W-1:0]       wr_rgb,
    output logic                       wr_ready,
    input  logic                       bank_req_valid,
    input  logic [$clog2(BANKS)-1:0]   bank_req,
    input  logic                       frame_start,
    output logic [$clog2(BANKS)-1:0]   active_bank,
    input  logic                       pix_valid,
    input  logic [INDEX_W-1:0]         index,
    input  logic                       flash_trig,
    output logic                       pix_valid_out,
    output logic                       transparent,
    output logic [COLOR_W-1:0]         red,
    output logic [COLOR_W-1:0]         green,
    output logic [COLOR_W-1:0]         blue
);

    localparam int BANK_W = $clog2(BANKS);
    localparam int AW     = BANK_W + INDEX_W;
    localparam int DEPTH  = BANKS << INDEX_W;
    localparam int RGB_W  = 3 * COLOR_W;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t             state, state_next;
    logic [AW-1:0]      clr_addr;

    logic               mem_we;
    logic [AW-1:0]      mem_addr;
    logic [RGB_W-1:0]   mem_wdata;
    logic [RGB_W-1:0]   mem [DEPTH];

    logic               pend_valid;
    logic [BANK_W-1:0]  pend_bank;

    logic               s1_valid;
    logic               s1_transp;
    logic [RGB_W-1:0]   s1_rgb;
    logic [RGB_W-1:0]   rgb_q;

    logic               flash_hit;

    // State register: reset (re)starts the palette clear.
    always_ff @(posedge Clk) begin
        // NOTE: every clocked register uses non-blocking assignment so all
        // flops sample the pre-edge values of each other.
        if (Reset) state <= CLEAR;
        else       state <= state_next;
    end

    // Next-state: leave CLEAR once the last palette address has been zeroed.
    always_comb begin
        state_next = state;
        if (state == CLEAR && clr_addr == LAST_ADDR) state_next = RUN;
    end

    // Output decode: the clear walker owns the write port until RUN.
    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned, which
        // would otherwise infer a latch.
        wr_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = clr_addr;
        mem_wdata = '0;
        if (state == CLEAR) begin
            mem_we = 1'b1;
        end else begin
            wr_ready  = 1'b1;
            mem_we    = wr_en;
            mem_addr  = {wr_bank, wr_index};
            mem_wdata = wr_rgb;
        end
    end

    // Clear address walker, {bank, index} from 0 to DEPTH-1.
    always_ff @(posedge Clk) begin
        if (Reset)               clr_addr <= '0;
        else if (state == CLEAR) clr_addr <= clr_addr + AW'(1);
    end

    // Palette storage write port.
    always_ff @(posedge Clk) begin
        // NOTE: the storage array has no reset; its contents are zeroed by
        // the CLEAR walk instead, which keeps it mappable to block RAM.
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    // Deferred bank select: latch requests, apply them on frame_start.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pend_valid  <= 1'b0;
            pend_bank   <= '0;
            active_bank <= '0;
        end else if (frame_start) begin
            // A request arriving with frame_start wins over an older one.
            if (bank_req_valid)  active_bank <= bank_req;
            else if (pend_valid) active_bank <= pend_bank;
            pend_valid <= 1'b0;
        end else if (bank_req_valid) begin
            pend_valid <= 1'b1;
            pend_bank  <= bank_req;
        end
    end

    // Stage 1: sample the bank and index and read storage. Reading at this
    // edge gives read-first behaviour against a write on the same edge and
    // lets a lookup issued the cycle after a write see the new data.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_valid  <= 1'b0;
            s1_transp <= 1'b0;
            s1_rgb    <= '0;
        end else begin
            s1_valid  <= pix_valid;
            s1_transp <= (index == '0);
            s1_rgb    <= mem[{active_bank, index}];
        end
    end

`ifdef PALETTE_FLASH_EN
    localparam int FC_W = $clog2(FLASH_FRAMES + 1);
    localparam logic [FC_W-1:0] FLASH_LOAD = FC_W'(FLASH_FRAMES);

    logic [FC_W-1:0] flash_cnt;

    // Flash frame counter: trigger (re)loads, frame_start counts down.
    always_ff @(posedge Clk) begin
        if (Reset)                              flash_cnt <= '0;
        else if (flash_trig)                    flash_cnt <= FLASH_LOAD;
        else if (frame_start && flash_cnt != '0) flash_cnt <= flash_cnt - FC_W'(1);
    end

    assign flash_hit = (flash_cnt != '0) && flash_cnt[0];
`else
    logic flash_unused;

    assign flash_unused = flash_trig | (FLASH_FRAMES == 0);
    assign flash_hit    = 1'b0;
`endif

    // Stage 2: register the looked-up colour, with flash override.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pix_valid_out <= 1'b0;
            transparent   <= 1'b0;
            rgb_q         <= '0;
        end else begin
            pix_valid_out <= s1_valid;
            transparent   <= s1_transp;
            rgb_q         <= (flash_hit && !s1_transp) ? '1 : s1_rgb;
        end
    end

    assign red   = rgb_q[RGB_W-1 -: COLOR_W];
    assign green = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign blue  = rgb_q[COLOR_W-1:0];

endmodule

// File: tb/tb_sprite_palette_bank.sv
// Directed self-checking bench for sprite_palette_bank (default parameters).
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_sprite_palette_bank;

`ifdef PALETTE_FLASH_EN
    localparam bit FLASH_ON = 1'b1;
`else
    localparam bit FLASH_ON = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_bank = '0;
    logic [3:0]  wr_index = '0;
    logic [11:0] wr_rgb = '0;
    logic        wr_ready;
    logic        bank_req_valid = 1'b0;
    logic [1:0]  bank_req = '0;
    logic        frame_start = 1'b0;
    logic [1:0]  active_bank;
    logic        pix_valid = 1'b0;
    logic [3:0]  index = '0;
    logic        flash_trig = 1'b0;
    logic        pix_valid_out;
    logic        transparent;
    logic [3:0]  red, green, blue;

    int total = 0;
    int bad   = 0;

    sprite_palette_bank dut (
        .Clk(Clk), .Reset(Reset),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_index(wr_index), .wr_rgb(wr_rgb),
        .wr_ready(wr_ready),
        .bank_req_valid(bank_req_valid), .bank_req(bank_req),
        .frame_start(frame_start), .active_bank(active_bank),
        .pix_valid(pix_valid), .index(index), .flash_trig(flash_trig),
        .pix_valid_out(pix_valid_out), .transparent(transparent),
        .red(red), .green(green), .blue(blue)
    );

    always #5 Clk = ~Clk;

    wire [11:0] rgb = {red, green, blue};

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic write(input logic [1:0] b, input logic [3:0] i, input logic [11:0] c);
        wr_en = 1'b1; wr_bank = b; wr_index = i; wr_rgb = c;
        step();
        wr_en = 1'b0;
    endtask

    // Issue one pixel and return the stage-2 result two cycles later.
    task automatic lookup(input logic [3:0] i, output logic [11:0] c,
                          output logic tr, output logic pv);
        pix_valid = 1'b1; index = i;
        step();
        pix_valid = 1'b0;
        step();
        c = rgb; tr = transparent; pv = pix_valid_out;
    endtask

    function automatic logic [11:0] flash_exp(input int cnt, input logic [11:0] base);
        return (FLASH_ON && cnt != 0 && (cnt % 2) == 1) ? 12'hFFF : base;
    endfunction

    task automatic test_reset();
        int n;
        logic [11:0] c; logic tr, pv;
        Reset = 1'b1; pix_valid = 1'b1; index = 4'd5;
        wr_en = 1'b1; wr_bank = 2'd0; wr_index = 4'd5; wr_rgb = 12'hFFF;
        step();
        total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL reset_wr_ready got=%b exp=0", wr_ready); end
        total++; if (active_bank !== 2'd0) begin bad++; $display("FAIL reset_active_bank got=%0d exp=0", active_bank); end
        total++; if (pix_valid_out !== 1'b0) begin bad++; $display("FAIL reset_pvo got=%b exp=0", pix_valid_out); end
        total++; if (transparent !== 1'b0) begin bad++; $display("FAIL reset_transp got=%b exp=0", transparent); end
        total++; if (rgb !== 12'h000) begin bad++; $display("FAIL reset_rgb got=%h exp=000", rgb); end
        Reset = 1'b0;
        n = 0;
        while (wr_ready !== 1'b1 && n < 200) begin
            step();
            n++;
            if (n == 10) begin
                total++; if (rgb !== 12'h000 || pix_valid_out !== 1'b1) begin
                    bad++; $display("FAIL clear_lookup got=%h/%b exp=000/1", rgb, pix_valid_out); end
            end
        end
        wr_en = 1'b0; pix_valid = 1'b0;
        total++; if (n != 64) begin bad++; $display("FAIL clear_cycles got=%0d exp=64", n); end
        lookup(4'd5, c, tr, pv);
        total++; if (c !== 12'h000) begin bad++; $display("FAIL after_clear_idx5 got=%h exp=000", c); end
    endtask

    task automatic test_write_read();
        logic [11:0] c; logic tr, pv;
        write(2'd0, 4'd1, 12'h320);
        write(2'd0, 4'd0, 12'hF0F);
        pix_valid = 1'b1; index = 4'd1;
        step();
        pix_valid = 1'b0;
        total++; if (pix_valid_out !== 1'b0) begin bad++; $display("FAIL latency_early got=%b exp=0", pix_valid_out); end
        step();
        total++; if (pix_valid_out !== 1'b1) begin bad++; $display("FAIL latency_pvo got=%b exp=1", pix_valid_out); end
        total++; if (rgb !== 12'h320) begin bad++; $display("FAIL read_idx1 got=%h exp=320", rgb); end
        total++; if (transparent !== 1'b0) begin bad++; $display("FAIL transp_idx1 got=%b exp=0", transparent); end
        step();
        total++; if (pix_valid_out !== 1'b0) begin bad++; $display("FAIL pvo_drop got=%b exp=0", pix_valid_out); end
        lookup(4'd0, c, tr, pv);
        total++; if (c !== 12'hF0F) begin bad++; $display("FAIL read_idx0 got=%h exp=F0F", c); end
        total++; if (tr !== 1'b1) begin bad++; $display("FAIL transp_idx0 got=%b exp=1", tr); end
    endtask

    task automatic test_read_first();
        wr_en = 1'b1; wr_bank = 2'd0; wr_index = 4'd2; wr_rgb = 12'hCCA;
        pix_valid = 1'b1; index = 4'd2;
        step();
        wr_en = 1'b0;
        step();
        pix_valid = 1'b0;
        total++; if (rgb !== 12'h000) begin bad++; $display("FAIL read_first_old got=%h exp=000", rgb); end
        step();
        total++; if (rgb !== 12'hCCA) begin bad++; $display("FAIL read_next_new got=%h exp=CCA", rgb); end
    endtask

    task automatic test_bank_switch();
        logic [11:0] c, exp; logic tr, pv;
        logic [1:0] exp_bank;
        write(2'd1, 4'd3, 12'h952);
        write(2'd0, 4'd3, 12'h100);
        // Continuous index-3 stream; request in cycle 2, frame_start in cycle 6.
        for (int cyc = 0; cyc < 12; cyc++) begin
            pix_valid = 1'b1; index = 4'd3;
            bank_req_valid = (cyc == 2); bank_req = 2'd1;
            frame_start = (cyc == 6);
            step();
            exp_bank = (cyc >= 6) ? 2'd1 : 2'd0;
            total++; if (active_bank !== exp_bank) begin
                bad++; $display("FAIL switch_bank c%0d got=%0d exp=%0d", cyc, active_bank, exp_bank); end
            if (cyc >= 1) begin
                exp = (cyc - 1 <= 6) ? 12'h100 : 12'h952;
                total++; if (rgb !== exp) begin
                    bad++; $display("FAIL switch_rgb c%0d got=%h exp=%h", cyc, rgb, exp); end
            end
        end
        pix_valid = 1'b0; bank_req_valid = 1'b0; frame_start = 1'b0;
        // Request coincident with frame_start applies immediately.
        write(2'd2, 4'd3, 12'hABC);
        bank_req_valid = 1'b1; bank_req = 2'd2; frame_start = 1'b1;
        step();
        bank_req_valid = 1'b0; frame_start = 1'b0;
        total++; if (active_bank !== 2'd2) begin bad++; $display("FAIL coincident_bank got=%0d exp=2", active_bank); end
        lookup(4'd3, c, tr, pv);
        total++; if (c !== 12'hABC) begin bad++; $display("FAIL coincident_rgb got=%h exp=ABC", c); end
        // A later request overwrites an earlier pending one.
        bank_req_valid = 1'b1; bank_req = 2'd3; step();
        bank_req = 2'd0; step();
        bank_req_valid = 1'b0;
        total++; if (active_bank !== 2'd2) begin bad++; $display("FAIL pending_hold got=%0d exp=2", active_bank); end
        frame_start = 1'b1; step(); frame_start = 1'b0;
        total++; if (active_bank !== 2'd0) begin bad++; $display("FAIL overwrite_bank got=%0d exp=0", active_bank); end
        // No pending request: frame_start leaves the bank alone.
        frame_start = 1'b1; step(); frame_start = 1'b0;
        total++; if (active_bank !== 2'd0) begin bad++; $display("FAIL no_pending_bank got=%0d exp=0", active_bank); end
    endtask

    task automatic test_flash();
        logic [11:0] c, exp; logic tr, pv;
        int cnt;
        flash_trig = 1'b1; step(); flash_trig = 1'b0;
        cnt = 8;
        lookup(4'd1, c, tr, pv);
        exp = flash_exp(cnt, 12'h320);
        total++; if (c !== exp) begin bad++; $display("FAIL flash_cnt8 got=%h exp=%h", c, exp); end
        for (int k = 1; k <= 8; k++) begin
            frame_start = 1'b1; step(); frame_start = 1'b0;
            cnt--;
            lookup(4'd1, c, tr, pv);
            exp = flash_exp(cnt, 12'h320);
            total++; if (c !== exp) begin bad++; $display("FAIL flash_idx1 cnt%0d got=%h exp=%h", cnt, c, exp); end
            lookup(4'd0, c, tr, pv);
            total++; if (c !== 12'hF0F || tr !== 1'b1) begin
                bad++; $display("FAIL flash_idx0 cnt%0d got=%h/%b exp=F0F/1", cnt, c, tr); end
        end
        // Counter at zero: extra frame_start must not wrap it.
        frame_start = 1'b1; step(); frame_start = 1'b0;
        lookup(4'd1, c, tr, pv);
        total++; if (c !== 12'h320) begin bad++; $display("FAIL flash_done got=%h exp=320", c); end
        // Trigger coincident with frame_start: reload, no decrement.
        flash_trig = 1'b1; frame_start = 1'b1; step(); flash_trig = 1'b0; frame_start = 1'b0;
        cnt = 8;
        lookup(4'd1, c, tr, pv);
        exp = flash_exp(cnt, 12'h320);
        total++; if (c !== exp) begin bad++; $display("FAIL flash_coincident got=%h exp=%h", c, exp); end
        frame_start = 1'b1; step(); frame_start = 1'b0;
        cnt = 7;
        lookup(4'd1, c, tr, pv);
        exp = flash_exp(cnt, 12'h320);
        total++; if (c !== exp) begin bad++; $display("FAIL flash_cnt7 got=%h exp=%h", c, exp); end
        // Retrigger while nonzero reloads to 8.
        flash_trig = 1'b1; step(); flash_trig = 1'b0;
        cnt = 8;
        lookup(4'd1, c, tr, pv);
        exp = flash_exp(cnt, 12'h320);
        total++; if (c !== exp) begin bad++; $display("FAIL flash_retrigger got=%h exp=%h", c, exp); end
    endtask

    task automatic test_reset_mid();
        logic [11:0] c; logic tr, pv;
        int n;
        write(2'd0, 4'd7, 12'h456);
        bank_req_valid = 1'b1; bank_req = 2'd2; frame_start = 1'b1;
        step();
        bank_req_valid = 1'b0; frame_start = 1'b0;
        pix_valid = 1'b1; index = 4'd7;
        step();
        step();
        total++; if (pix_valid_out !== 1'b1) begin bad++; $display("FAIL mid_pvo_before got=%b exp=1", pix_valid_out); end
        Reset = 1'b1;
        step();
        Reset = 1'b0; pix_valid = 1'b0;
        total++; if (pix_valid_out !== 1'b0) begin bad++; $display("FAIL mid_pvo_flush got=%b exp=0", pix_valid_out); end
        total++; if (active_bank !== 2'd0) begin bad++; $display("FAIL mid_active_bank got=%0d exp=0", active_bank); end
        total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL mid_wr_ready got=%b exp=0", wr_ready); end
        n = 0;
        while (wr_ready !== 1'b1 && n < 200) begin step(); n++; end
        total++; if (n != 64) begin bad++; $display("FAIL mid_clear_cycles got=%0d exp=64", n); end
        lookup(4'd7, c, tr, pv);
        total++; if (c !== 12'h000) begin bad++; $display("FAIL mid_entry_lost got=%h exp=000", c); end
        lookup(4'd1, c, tr, pv);
        total++; if (c !== 12'h000) begin bad++; $display("FAIL mid_idx1_lost got=%h exp=000", c); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_read_first();
        test_bank_switch();
        // Back to bank 0 for the flash checks.
        bank_req_valid = 1'b1; bank_req = 2'd0; frame_start = 1'b1; step();
        bank_req_valid = 1'b0; frame_start = 1'b0;
        test_flash();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
